transmissor_malha: RTL
======================

// Module: transmissor_malha
// PURPOSE
//  Reader/serializer of the occupancy grid produced by the mapping block (mapas).
//  On each completed map update it snapshots the 2-bit-per-cell grid and streams it
//  as a byte frame over a valid/ready handshake toward the UART/host link.
//  Frame: header byte, packed cell bytes, optional checksum byte.
// PARAMETERS
//  TamanhoMalha  9      grid side; the grid holds TamanhoMalha*TamanhoMalha cells
//  CABECALHO     8'hA5  frame start byte
// PORTS
//  clock               in   1        single clock; all logic on posedge
//  reset               in   1        synchronous, active-high
//  malha               in   2 x N*N  unpacked grid; cell index i*TamanhoMalha+j
//  operacaoFinalizada  in   1        mapper done flag; rising edge requests a frame
//  dadoSaida           out  8        byte being offered
//  dadoValido          out  1        dadoSaida is valid
//  dadoPronto          in   1        sink accepts the byte when dadoValido && dadoPronto
//  ocupado             out  1        a frame is in progress (snapshot to last byte)
//  quadroEnviado       out  1        1-cycle pulse after the last byte of a frame is accepted
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=OCIOSO; pendente=0; edge detector register=0.
//  - Start: edge = operacaoFinalizada & ~op_q. A level held high triggers once.
//  - In OCIOSO, an edge (or pendente=1) copies malha into a snapshot in the same clock.
//    The next cycle the FSM enters CABECALHO with dadoValido=1 and dadoSaida=CABECALHO.
//  - States: OCIOSO -> CABECALHO -> DADOS -> [CHECKSUM] -> OCIOSO.
//    A state advances only on an accept (dadoValido & dadoPronto).
//  - DADOS sends NB = ceil(N*N/4) bytes. For N=9, NB=21.
//    Byte k bits[2m+1:2m] = cell 4k+m (m=0..3). Cells beyond N*N-1 are padded with 0.
//  - Byte counter width is $clog2(NB+1). It clears on entry to DADOS and never wraps inside a frame.
//  - Handshake: while dadoValido=1 && dadoPronto=0, dadoSaida holds stable and dadoValido stays 1.
//    dadoValido never drops mid-frame except on reset.
//  - Back-to-back: after the last accept, dadoValido=0 for at least 1 cycle (the OCIOSO cycle).
//  - Frame content comes only from the snapshot. Changes to malha mid-frame do not affect the current frame.
//  - An edge while ocupado=1 sets pendente. Only one request is queued; further edges are dropped.
//    On reaching OCIOSO with pendente=1: take a new snapshot, clear pendente, start the next frame.
//  - Simultaneous last accept and new edge: pendente is set, and the next frame follows.
//  - quadroEnviado pulses in the cycle after the final accept. ocupado falls in that same cycle.
//  - Reset mid-frame: the next cycle dadoValido=0, ocupado=0, pendente=0, and the frame is discarded.
// CONFIGURATION
//  MALHA_CHECKSUM_EN defined:
//    - After DADOS, send a CHECKSUM byte = XOR of all NB data bytes (header excluded).
//    - Frame length is NB+2.
//  MALHA_CHECKSUM_EN undefined:
//    - The CHECKSUM state and XOR accumulator are not built.
//    - DADOS goes directly to OCIOSO; frame length is NB+1.
// STRUCTURE
//  - Package mapas_pkg holds:
//    - celula_t (logic [1:0]) and the estado_t enum {OCIOSO,CABECALHO,DADOS,CHECKSUM}.
//    - Constant CABECALHO_PADRAO = 8'hA5.
//    - Function numBytes(N) = (N*N+3)/4.
//    - Function empacota(snapshot,k) returning byte k.
//  - No sub-module: the FSM, snapshot register and XOR accumulator stay in one module.
//    Packing is the package function.
// TESTING
//  (N=9, checksum enabled unless noted; sink dadoPronto=1 unless noted)
//  1. All cells 0; pulse operacaoFinalizada
//     -> A5, 21x 00, checksum 00; quadroEnviado one pulse; 23 accepts.
//  2. cell0=1, cell5=3, cell80=2
//     -> byte0=01, byte1=0C, byte20=02, checksum=0F.
//  3. dadoPronto=0 for 5 cycles while byte 3 is offered
//     -> dadoSaida/dadoValido stable for all 5 cycles; no byte lost or duplicated.
//  4. Mid-frame: overwrite malha with all 1s, give a second rising edge, then a third
//     -> frame 1 is unchanged; exactly one more frame follows; byte0=55 in frame 2.
//  5. Hold operacaoFinalizada high for 100 cycles -> exactly 1 frame.
//     Assert reset at byte 10 -> next cycle dadoValido=0, ocupado=0; no frame resumes.
//  6. Build without MALHA_CHECKSUM_EN, all cells 2
//     -> A5, 20x AA, then 02; 22 accepts; the FSM never enters CHECKSUM.

Source files
------------

// File: rtl/transmissor_malha_pkg.sv
// Shared types and helpers for the occupancy-grid frame serializer.
package mapas_pkg;

  typedef logic [1:0] celula_t;

  typedef enum logic [1:0] {
    OCIOSO,
    CABECALHO,
    DADOS,
    CHECKSUM
  } estado_t;

  localparam logic [7:0] CABECALHO_PADRAO = 8'hA5;

  // Largest grid side the packing helper accepts
  localparam int unsigned TAMANHO_MAX = 32;

  function automatic int unsigned numBytes(input int unsigned n);
    return (n * n + 3) / 4;
  endfunction

  localparam int unsigned BITS_MAX = 8 * numBytes(TAMANHO_MAX);

  // Snapshot is stored flattened with four 2-bit cells per byte, padding zeroed
  function automatic logic [7:0] empacota(input logic [BITS_MAX-1:0] snapshot,
                                          input int unsigned k);
    return snapshot[8*k +: 8];
  endfunction

endpackage

// File: rtl/transmissor_malha_if.sv
// Byte stream handshake between the grid serializer and the host link.
interface transmissor_malha_if;
  logic [7:0] dadoSaida;
  logic       dadoValido;
  logic       dadoPronto;

  modport master (output dadoSaida, output dadoValido, input dadoPronto);
  modport slave  (input dadoSaida, input dadoValido, output dadoPronto);
endinterface

// File: rtl/transmissor_malha.sv
// Snapshots the mapper grid on each completed update and streams it as a byte frame.
// Define MALHA_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module transmissor_malha #(
  parameter int unsigned TamanhoMalha = 9,
  parameter logic [7:0]  CABECALHO    = mapas_pkg::CABECALHO_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset,
  input  mapas_pkg::celula_t    malha [TamanhoMalha*TamanhoMalha],
  input  logic                  operacaoFinalizada,
  transmissor_malha_if.master   saida,
  output logic                  ocupado,
  output logic                  quadroEnviado
);
  import mapas_pkg::*;

  localparam int unsigned NC = TamanhoMalha * TamanhoMalha;
  localparam int unsigned NB = numBytes(TamanhoMalha);
  localparam int unsigned LC = $clog2(NB + 1);
  localparam logic [LC-1:0] ULTIMO = LC'(NB - 1);

  estado_t          estado, estadoProx;
  logic             opQ, pendente, borda, aceite, ultimoDado;
  logic [LC-1:0]    contador;
  logic [8*NB-1:0]  snapshot, malhaPlana;
  logic [BITS_MAX-1:0] snapshotEstendido;
`ifdef MALHA_CHECKSUM_EN
  logic [7:0]       somaXor;
`endif

  always_comb begin
    malhaPlana = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      malhaPlana[2*i +: 2] = malha[i];
    end
  end

  assign snapshotEstendido = BITS_MAX'(snapshot);
  assign borda      = operacaoFinalizada & ~opQ;
  assign ultimoDado = (contador == ULTIMO);
  assign ocupado    = (estado != OCIOSO);

  always_comb begin
    estadoProx       = estado;
    saida.dadoValido = 1'b0;
    saida.dadoSaida  = '0;
    case (estado)
      OCIOSO: begin
        if (borda || pendente) estadoProx = mapas_pkg::CABECALHO;
      end
      mapas_pkg::CABECALHO: begin
        saida.dadoValido = 1'b1;
        saida.dadoSaida  = CABECALHO;
        if (saida.dadoPronto) estadoProx = DADOS;
      end
      DADOS: begin
        saida.dadoValido = 1'b1;
        saida.dadoSaida  = empacota(snapshotEstendido, 32'(contador));
        if (saida.dadoPronto && ultimoDado) begin
`ifdef MALHA_CHECKSUM_EN
          estadoProx = CHECKSUM;
`else
          estadoProx = OCIOSO;
`endif
        end
      end
`ifdef MALHA_CHECKSUM_EN
      CHECKSUM: begin
        saida.dadoValido = 1'b1;
        saida.dadoSaida  = somaXor;
        if (saida.dadoPronto) estadoProx = OCIOSO;
      end
`endif
      default: estadoProx = OCIOSO;
    endcase
    aceite = saida.dadoValido & saida.dadoPronto;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= OCIOSO;
      opQ           <= 1'b0;
      pendente      <= 1'b0;
      quadroEnviado <= 1'b0;
      contador      <= '0;
      snapshot      <= '0;
    end else begin
      estado        <= estadoProx;
      opQ           <= operacaoFinalizada;
      // Only the final accept of a frame leads back to OCIOSO
      quadroEnviado <= aceite && (estadoProx == OCIOSO);

      if (estado == OCIOSO) begin
        if (borda || pendente) begin
          snapshot <= malhaPlana;
          pendente <= 1'b0;
        end
      end else if (borda) begin
        pendente <= 1'b1;
      end

      if (estado == mapas_pkg::CABECALHO && aceite) begin
        contador <= '0;
      end else if (estado == DADOS && aceite && !ultimoDado) begin
        contador <= contador + LC'(1);
      end
    end
  end

`ifdef MALHA_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      somaXor <= '0;
    end else if (estado == mapas_pkg::CABECALHO && aceite) begin
      somaXor <= '0;
    end else if (estado == DADOS && aceite) begin
      somaXor <= somaXor ^ saida.dadoSaida;
    end
  end
`endif

endmodule
